conv1_mac: RTL

Stage-1 convolution engine directly downstream of the input-data streamer. Holds one 32-tap signed weight kernel and consumes 32-sample bursts from `data_in_conv1`/`valid_conv1`. Each burst yields one multiply-accumulate result, which is passed through ReLU, shift and saturation and presented on `out_data`. It also generates the control the streamer consumes: `c1_w_en` (weights ready), `conv_time` (completed-window count), `out_valid`, and `conv_end`, whose falling edge requests the next burst.

---
 rtl/conv1_pkg.sv | 45 ++++
 rtl/conv1_mac_dp.sv | 60 ++++++
 rtl/conv1_mac.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/conv1_pkg.sv
// conv1_pkg: shared widths, state encoding and the output post-processing
// helper for the stage-1 convolution engine (conv1_mac / conv1_mac_dp).
package conv1_pkg;

  localparam int DATA_W    = 8;     // sample width, signed
  localparam int W_W       = 8;     // weight width, signed
  localparam int PROD_W    = DATA_W + W_W;
  localparam int ACC_W     = 24;    // accumulator width, signed
  localparam int OUT_W     = 16;    // result width
  localparam int BURST_LEN = 32;    // taps per window = samples per burst
  localparam int IDX_W     = 5;     // index width for BURST_LEN entries
  localparam int TIME_W    = 13;    // conv_time width
  localparam int NUM_CONV  = 2688;  // windows per frame
  localparam int SHIFT     = 7;     // right shift before saturation

  typedef enum logic [2:0] {
    LOAD_W = 3'd0,
    ACCUM  = 3'd1,
    DRAIN  = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // ReLU, arithmetic right shift, then clamp to the unsigned OUT_W range.
  function automatic logic [OUT_W-1:0] relu_shift_sat(
    input logic signed [ACC_W-1:0] acc,
    input int unsigned             shift
  );
    logic [ACC_W-1:0] mag;
    logic [OUT_W-1:0] res;
    mag = '0;
    if (acc[ACC_W-1]) begin
      res = '0;
    end else begin
      mag = $unsigned(acc) >> shift;
      if (|mag[ACC_W-1:OUT_W]) begin
        res = '1;
      end else begin
        res = mag[OUT_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/conv1_mac_dp.sv
// conv1_mac_dp: registered signed multiplier feeding a signed accumulator.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        synchronous clear of product pipe and accumulator
//   sample_en    a sample is accepted this cycle
//   first        the accepted sample is tap 0 of a new window
//   sample       signed sample
//   weight       signed weight for the accepted tap
//   acc          running accumulator (one cycle behind the product)
module conv1_mac_dp
  import conv1_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     sample_en,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [W_W-1:0]    weight,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod_r;
  logic                     prod_vld_r;
  logic                     prod_first_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  prod_ext_s;

  // Sign-extend the registered product to accumulator width.
  always_comb begin
    prod_ext_s = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
  end

  // Product stage then accumulate stage; the first tap loads rather than adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r       <= '0;
      prod_vld_r   <= 1'b0;
      prod_first_r <= 1'b0;
      acc_r        <= '0;
    end else if (clear) begin
      prod_r       <= '0;
      prod_vld_r   <= 1'b0;
      prod_first_r <= 1'b0;
      acc_r        <= '0;
    end else begin
      prod_vld_r   <= sample_en;
      prod_first_r <= first;
      if (sample_en) begin
        prod_r <= sample * weight;
      end
      if (prod_vld_r) begin
        acc_r <= prod_first_r ? prod_ext_s : (acc_r + prod_ext_s);
      end
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/conv1_mac.sv
// conv1_mac: stage-1 convolution engine. Loads a 32-tap signed kernel,
// accumulates one 32-sample burst per window, and emits ReLU/shift/saturated
// results plus the handshake the input streamer consumes.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   valid            frame enable; low acts as synchronous soft clear
//   w_valid, w_data  weight word strobe and data (tap 0 first)
//   valid_conv1      sample strobe; data_in_conv1 signed sample
//   c1_w_en          all weights loaded
//   out_valid        one-cycle result strobe with out_data
//   conv_end         one-cycle window-complete pulse (falling edge = next burst)
//   conv_time        windows completed in this frame
//   frame_done       conv_time reached NUM_CONV (sticky until soft clear)
//   overrun          sticky: a sample arrived outside ACCUM
module conv1_mac
  import conv1_pkg::*;
#(
  parameter int SHIFT    = conv1_pkg::SHIFT,
  parameter int NUM_CONV = conv1_pkg::NUM_CONV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              w_valid,
  input  logic [W_W-1:0]    w_data,
  input  logic              valid_conv1,
  input  logic [DATA_W-1:0] data_in_conv1,
  output logic              c1_w_en,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              conv_end,
  output logic [TIME_W-1:0] conv_time,
  output logic              frame_done,
  output logic              overrun
);

  state_t state_r, state_nx;

  logic [W_W-1:0]    weight_r [BURST_LEN];
  logic [IDX_W-1:0]  w_idx_r;
  logic [IDX_W-1:0]  s_idx_r;
  logic              c1_w_en_r;
  logic              out_valid_r;
  logic [OUT_W-1:0]  out_data_r;
  logic              conv_end_r;
  logic [TIME_W-1:0] conv_time_r;
  logic              frame_done_r;
  logic              overrun_r;

  logic              w_we_s;
  logic              s_acc_s;
  logic              emit_s;
  logic              ovr_s;
  logic              last_w_s;
  logic              last_s_s;
  logic              time_hit_s;
  logic [TIME_W-1:0] time_nx_s;
  logic signed [ACC_W-1:0] acc_s;

  // Window counter after this emit and whether it closes the frame.
  always_comb begin
    time_nx_s  = conv_time_r + {{(TIME_W-1){1'b0}}, 1'b1};
    time_hit_s = (time_nx_s == TIME_W'(NUM_CONV));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD_W;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; soft clear overrides every state.
  always_comb begin
    state_nx = state_r;
    if (!valid) begin
      state_nx = c1_w_en_r ? ACCUM : LOAD_W;
    end else begin
      case (state_r)
        LOAD_W:  state_nx = last_w_s ? ACCUM : LOAD_W;
        ACCUM:   state_nx = last_s_s ? DRAIN : ACCUM;
        DRAIN:   state_nx = EMIT;
        EMIT:    state_nx = time_hit_s ? DONE : ACCUM;
        DONE:    state_nx = DONE;
        default: state_nx = LOAD_W;
      endcase
    end
  end

  // Per-state control strobes; a weight strobe outside LOAD_W is ignored.
  always_comb begin
    w_we_s   = 1'b0;
    s_acc_s  = 1'b0;
    emit_s   = 1'b0;
    ovr_s    = 1'b0;
    if (valid) begin
      case (state_r)
        LOAD_W: begin
          w_we_s = w_valid;
          ovr_s  = valid_conv1;
        end
        ACCUM:   s_acc_s = valid_conv1;
        DRAIN:   ovr_s   = valid_conv1;
        EMIT: begin
          emit_s = 1'b1;
          ovr_s  = valid_conv1;
        end
        DONE:    ovr_s   = valid_conv1;
        default: ovr_s   = 1'b0;
      endcase
    end else begin
      w_we_s = 1'b0;
    end
    last_w_s = w_we_s && (w_idx_r == IDX_W'(BURST_LEN-1));
    last_s_s = s_acc_s && (s_idx_r == IDX_W'(BURST_LEN-1));
  end

  // Weight register file; only a hard reset forgets the kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        weight_r[i] <= '0;
      end
    end else if (w_we_s) begin
      weight_r[w_idx_r] <= w_data;
    end
  end

  // Weight index and weights-ready flag, both kept across soft clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx_r   <= '0;
      c1_w_en_r <= 1'b0;
    end else begin
      if (w_we_s) begin
        w_idx_r <= w_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (last_w_s) begin
        c1_w_en_r <= 1'b1;
      end
    end
  end

  // Sample index, window counter and the registered result/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_idx_r      <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      conv_end_r   <= 1'b0;
      conv_time_r  <= '0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (!valid) begin
      s_idx_r      <= '0;
      out_valid_r  <= 1'b0;
      conv_end_r   <= 1'b0;
      conv_time_r  <= '0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      out_valid_r <= emit_s;
      conv_end_r  <= emit_s;
      overrun_r   <= overrun_r | ovr_s;
      if (s_acc_s) begin
        s_idx_r <= s_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (emit_s) begin
        s_idx_r     <= '0;
        out_data_r  <= relu_shift_sat(acc_s, SHIFT);
        conv_time_r <= time_nx_s;
        if (time_hit_s) begin
          frame_done_r <= 1'b1;
        end
      end
    end
  end

  conv1_mac_dp u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (!valid),
    .sample_en (s_acc_s),
    .first     (s_idx_r == '0),
    .sample    (data_in_conv1),
    .weight    (weight_r[s_idx_r]),
    .acc       (acc_s)
  );

  assign c1_w_en    = c1_w_en_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign conv_end   = conv_end_r;
  assign conv_time  = conv_time_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule
